// File: rtl/dot_pkg.sv
// Shared types and helpers for the dot-matrix row scanner.
// Scan states, index-width helper and parameter legality check.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    localparam int DEF_CLK_DIV   = 12500;
    localparam int DEF_N_ROWS    = 10;
    localparam int DEF_N_COLS    = 14;
    localparam int DEF_SRC_ROWS  = 11;
    localparam int DEF_BLANK_CYC = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(
        input int n_rows,
        input int src_rows,
        input int clk_div,
        input int blank_cyc
    );
        return (n_rows > 0) && (clk_div > 0) &&
               (src_rows >= n_rows) && (blank_cyc < clk_div);
    endfunction

endpackage

// File: rtl/dot_frame_buffer.sv
// Double-buffered frame store: writes go to the back buffer,
// reads come from the front buffer, swap toggles the front select.
module dot_frame_buffer
    import dot_pkg::*;
#(
    parameter int SRC_ROWS = DEF_SRC_ROWS,
    parameter int N_COLS   = DEF_N_COLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [idx_w(SRC_ROWS)-1:0] wr_row_i,
    input  logic [N_COLS-1:0]          wr_data_i,
    input  logic [idx_w(SRC_ROWS)-1:0] rd_row_i,
    output logic [N_COLS-1:0]          rd_data_o,
    input  logic                       swap_req_i,
    input  logic                       swap_go_i,
    output logic                       swap_ack_o
);

    logic              front_q;
    logic              pend_q;
    logic              ack_q;
    logic              do_swap;
    logic [N_COLS-1:0] mem_q [2][SRC_ROWS];

    // A request arriving in the same cycle as a swap window executes at once.
    assign do_swap = swap_go_i & (pend_q | swap_req_i);

    // Front select, pending flag, ack pulse and the register file.
    // Writes always target the pre-swap back buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            for (int r = 0; r < SRC_ROWS; r++) begin
                mem_q[0][r] <= '0;
                mem_q[1][r] <= '0;
            end
        end else begin
            ack_q  <= do_swap;
            pend_q <= (pend_q | swap_req_i) & ~do_swap;
            if (do_swap) begin
                front_q <= ~front_q;
            end
            if (wr_en_i && (int'(wr_row_i) < SRC_ROWS)) begin
                mem_q[~front_q][wr_row_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o  = mem_q[front_q][rd_row_i];
    assign swap_ack_o = ack_q;

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for the multiplexed dot-matrix display.
// Holds the tick divider, scan FSM, offset latch and output registers.
module dot_matrix_scanner
    import dot_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int N_ROWS    = DEF_N_ROWS,
    parameter int N_COLS    = DEF_N_COLS,
    parameter int SRC_ROWS  = DEF_SRC_ROWS,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [idx_w(SRC_ROWS)-1:0] row_offset,
    input  logic                       wr_en,
    input  logic [idx_w(SRC_ROWS)-1:0] wr_row,
    input  logic [N_COLS-1:0]          wr_data,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       frame_tick,
    output logic [N_ROWS-1:0]          dot_row,
    output logic [N_COLS-1:0]          dot_col
);

    localparam int RW      = idx_w(SRC_ROWS);
    localparam int NW      = idx_w(N_ROWS);
    localparam int DW      = idx_w(CLK_DIV);
    localparam int MAX_OFF = SRC_ROWS - N_ROWS;

    if (!params_ok(N_ROWS, SRC_ROWS, CLK_DIV, BLANK_CYC)) begin : g_bad_params
        $error("dot_matrix_scanner: need SRC_ROWS>=N_ROWS and BLANK_CYC<CLK_DIV");
    end

    scan_state_t       state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [NW-1:0]     row_q, row_d;
    logic [RW-1:0]     off_q, off_d;
    logic [RW-1:0]     off_clamped;
    logic [RW-1:0]     src;
    logic              tick;
    logic              wrap;
    logic              swap_go;
    logic [N_COLS-1:0] rd_data;
    logic [N_ROWS-1:0] dot_row_d, dot_row_q;
    logic [N_COLS-1:0] dot_col_d, dot_col_q;
    logic              tick_q;

    // The visible window never runs past the last stored row.
    assign off_clamped = (int'(row_offset) > MAX_OFF) ? RW'(MAX_OFF)
                                                      : row_offset;
    assign src     = RW'(row_q) + off_q;
    assign tick    = (div_q == DW'(CLK_DIV - 1));
    assign wrap    = enable && (state_q == SHOW) && tick &&
                     (row_q == NW'(N_ROWS - 1));
    assign swap_go = (state_q == IDLE) || wrap;

    // Next-state logic for the scan FSM, divider, row index and offset.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        row_d   = row_q;
        off_d   = off_q;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                row_d = '0;
                if (enable) begin
                    state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                    off_d   = off_clamped;
                end
            end
            BLANK: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (div_q == DW'(BLANK_CYC - 1)) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                    if (row_q == NW'(N_ROWS - 1)) begin
                        row_d = '0;
                        off_d = off_clamped;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!enable) begin
            state_d = IDLE;
            div_d   = '0;
            row_d   = '0;
        end
    end

    // Output decode; dropping enable darkens the pins on the very next edge.
    always_comb begin
        dot_row_d = '0;
        dot_col_d = '0;
        if (enable && (state_q == SHOW)) begin
            dot_row_d = {{(N_ROWS-1){1'b0}}, 1'b1} << row_q;
            dot_col_d = rd_data;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            row_q     <= '0;
            off_q     <= '0;
            dot_row_q <= '0;
            dot_col_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            row_q     <= row_d;
            off_q     <= off_d;
            dot_row_q <= dot_row_d;
            dot_col_q <= dot_col_d;
            tick_q    <= wrap;
        end
    end

    dot_frame_buffer #(
        .SRC_ROWS (SRC_ROWS),
        .N_COLS   (N_COLS)
    ) u_fb (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_row_i   (wr_row),
        .wr_data_i  (wr_data),
        .rd_row_i   (src),
        .rd_data_o  (rd_data),
        .swap_req_i (swap_req),
        .swap_go_i  (swap_go),
        .swap_ack_o (swap_ack)
    );

    assign dot_row    = dot_row_q;
    assign dot_col    = dot_col_q;
    assign frame_tick = tick_q;

endmodule
